// File: rtl/ctrl_fsm_pkg.sv
// Shared opcodes, FSM state encoding and instruction field helpers for the
// 8-bit multi-cycle core control path.
package ctrl_fsm_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_HALT = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_LW   = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  function automatic logic [2:0] ir_op(input logic [7:0] ir);
    return ir[7:5];
  endfunction

  function automatic logic ir_rt(input logic [7:0] ir);
    return ir[4];
  endfunction

  function automatic logic ir_rs(input logic [7:0] ir);
    return ir[3];
  endfunction

  function automatic logic [2:0] ir_imm(input logic [7:0] ir);
    return ir[2:0];
  endfunction

endpackage

// File: rtl/ctrl_fsm_decode.sv
// Combinational instruction classifier: maps the latched instruction word to
// operand-source and instruction-class flags used by the sequencer.
module ctrl_fsm_decode
  import ctrl_fsm_pkg::*;
(
  input  logic [7:0] i_ir,
  output logic       o_alusrc,
  output logic       o_is_mem,
  output logic       o_is_store,
  output logic       o_is_halt,
  output logic       o_is_illegal
);

  // Opcode to class flags; the two unassigned opcodes fall into default.
  always_comb begin
    o_alusrc     = 1'b0;
    o_is_mem     = 1'b0;
    o_is_store   = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    case (ir_op(i_ir))
      OP_ADD:          o_alusrc = 1'b1;
      OP_ADDI, OP_SLL: o_alusrc = 1'b0;
      OP_SW: begin
        o_is_mem   = 1'b1;
        o_is_store = 1'b1;
      end
      OP_LW:           o_is_mem = 1'b1;
      OP_HALT:         o_is_halt = 1'b1;
      default:         o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control sequencer: owns PC and IR, sequences fetch, decode,
// execute, data-memory access and write-back, with an ack timeout watchdog.
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int ACK_TMO  = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            alusrc,
  output logic [2:0]      alu_op,
  output logic [2:0]      imm,
  output logic            rs_sel,
  output logic            rt_sel,
  output logic            wr_sel,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal_op,
  output logic            bus_err
);

  localparam int                TMO_W    = $clog2(ACK_TMO + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ACK_TMO - 1);
  localparam logic [PC_W-1:0]   RST_PC   = PC_W'(RESET_PC);

  state_t            r_state;
  logic [7:0]        r_ir;
  logic [PC_W-1:0]   r_pc;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_imem_req;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic              r_halted;
  logic              r_illegal;
  logic              r_bus_err;

  logic w_alusrc;
  logic w_is_mem;
  logic w_is_store;
  logic w_is_halt;
  logic w_is_illegal;

  ctrl_fsm_decode u_decode (
    .i_ir         (r_ir),
    .o_alusrc     (w_alusrc),
    .o_is_mem     (w_is_mem),
    .o_is_store   (w_is_store),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  // Sequencer: state, PC/IR, watchdog counter and every registered control output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_ir         <= 8'h00;
      r_pc         <= RST_PC;
      r_tmo        <= '0;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_halted     <= 1'b0;
      r_illegal    <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // An ack only counts once our request is actually on the bus.
          if (r_imem_req && imem_ack) begin
            r_ir       <= imem_rdata;
            r_pc       <= r_pc + PC_W'(1);
            r_imem_req <= 1'b0;
            r_tmo      <= '0;
            r_state    <= S_DECODE;
          end else if (r_imem_req && (r_tmo == TMO_LAST)) begin
            r_imem_req <= 1'b0;
            r_bus_err  <= 1'b1;
            r_halted   <= 1'b1;
            r_state    <= S_HALT;
          end else begin
            r_imem_req <= 1'b1;
            if (r_imem_req) r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_DECODE: begin
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (w_is_illegal) begin
            r_illegal  <= 1'b1;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_mem) begin
            r_dmem_req <= 1'b1;
            r_dmem_we  <= w_is_store;
            r_tmo      <= '0;
            r_state    <= S_MEM;
          end else begin
            r_reg_write <= 1'b1;
            r_state     <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_tmo      <= '0;
            if (w_is_store) begin
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_reg_write  <= 1'b1;
              r_mem_to_reg <= 1'b1;
              r_state      <= S_WB;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_bus_err  <= 1'b1;
            r_halted   <= 1'b1;
            r_state    <= S_HALT;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_WB: begin
          r_reg_write  <= 1'b0;
          r_mem_to_reg <= 1'b0;
          r_imem_req   <= 1'b1;
          r_state      <= S_FETCH;
        end
        S_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign alusrc     = w_alusrc;
  assign alu_op     = ir_op(r_ir);
  assign imm        = ir_imm(r_ir);
  assign rs_sel     = ir_rs(r_ir);
  assign rt_sel     = ir_rt(r_ir);
  assign wr_sel     = ir_rt(r_ir);
  assign reg_write  = r_reg_write;
  assign mem_to_reg = r_mem_to_reg;
  assign halted     = r_halted;
  assign illegal_op = r_illegal;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed vector table, randomized program
// against an instruction-level timing model, and reset/timeout/halt sequences.
module tb_ctrl_fsm;
  localparam int PC_W    = 8;
  localparam int ACK_TMO = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [PC_W-1:0] imem_addr, pc;
  logic [7:0]      imem_rdata;
  logic            alusrc, rs_sel, rt_sel, wr_sel, reg_write, mem_to_reg;
  logic [2:0]      alu_op, imm;
  logic            halted, illegal_op, bus_err;

  ctrl_fsm #(.PC_W(PC_W), .RESET_PC(0), .ACK_TMO(ACK_TMO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alusrc(alusrc), .alu_op(alu_op), .imm(imm), .rs_sel(rs_sel), .rt_sel(rt_sel),
    .wr_sel(wr_sel), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc(pc),
    .halted(halted), .illegal_op(illegal_op), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    int         d_i;     // cycles imem_ack is withheld after req appears
    int         d_m;     // cycles dmem_ack is withheld after req appears
    int         lat;     // cycles from fetch-ack cycle to next fetch request (or halt)
    int         wb;      // reg_write pulse cycles
    int         memc;    // dmem_req cycles
    bit         m2r;
    bit         we;
    bit         alusrc;
    bit         halt;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_pc;
  bit         exp_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction-level reference: latency is the sum of the phases the opcode visits.
  function automatic vec_t model(input logic [7:0] ins, input int di, input int dm);
    vec_t       v;
    logic [2:0] op;
    bit         ill, mem, st, hlt;
    op  = ins[7:5];
    ill = (op == 3'd1) || (op == 3'd2);
    mem = (op == 3'd5) || (op == 3'd6);
    st  = (op == 3'd5);
    hlt = (op == 3'd3);
    v.instr  = ins;
    v.d_i    = di;
    v.d_m    = dm;
    v.wb     = (!ill && !st && !hlt) ? 1 : 0;
    v.memc   = mem ? dm + 1 : 0;
    v.m2r    = (op == 3'd6);
    v.we     = st;
    v.alusrc = (op == 3'd0);
    v.halt   = hlt;
    v.lat    = 2 + ((ill || hlt) ? 0 : 1 + v.memc + v.wb);
    return v;
  endfunction

  task automatic wait_ireq(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_instr(input vec_t v, input string tag);
    bit ok, held, m2r, we_bad;
    int lat, wbc, memc;
    wait_ireq(ok);
    chk({tag, " fetch_req"}, ok, 1);
    chk({tag, " imem_addr"}, imem_addr, exp_pc);
    held = 1'b1;
    for (int i = 0; i < v.d_i; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) held = 1'b0;
    end
    chk({tag, " ireq_held"}, held, 1);
    imem_ack   = 1'b1;
    imem_rdata = v.instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 8'($urandom);
    exp_pc     = exp_pc + 8'd1;
    if (v.instr[7:5] == 3'd1 || v.instr[7:5] == 3'd2) exp_ill = 1'b1;
    chk({tag, " pc"}, pc, exp_pc);
    chk({tag, " ireq_drop"}, imem_req, 0);
    chk({tag, " alu_op"}, alu_op, v.instr[7:5]);
    chk({tag, " imm"}, imm, v.instr[2:0]);
    chk({tag, " sel"}, {rs_sel, rt_sel, wr_sel}, {v.instr[3], v.instr[4], v.instr[4]});
    chk({tag, " alusrc"}, alusrc, v.alusrc);
    lat = 1; wbc = 0; memc = 0; m2r = 1'b0; we_bad = 1'b0;
    while (lat < 40) begin
      if (imem_req === 1'b1 || halted === 1'b1) break;
      if (reg_write === 1'b1) begin
        wbc++;
        m2r = mem_to_reg;
      end
      if (dmem_req === 1'b1) begin
        memc++;
        if (dmem_we !== v.we) we_bad = 1'b1;
        if (memc == v.d_m + 1) dmem_ack = 1'b1;
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      lat++;
    end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " reg_write_cycles"}, wbc, v.wb);
    chk({tag, " mem_to_reg"}, m2r, v.m2r);
    chk({tag, " dmem_req_cycles"}, memc, v.memc);
    chk({tag, " dmem_we"}, we_bad, 0);
    chk({tag, " halted"}, halted, v.halt);
    chk({tag, " illegal_op"}, illegal_op, exp_ill);
    chk({tag, " bus_err"}, bus_err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[7];
    vec_t       v;
    bit         ok, bad;
    logic [7:0] ins;

    // Hand-computed expectations {instr, d_i, d_m, lat, wb, memc, m2r, we, alusrc, halt}
    tbl[0] = '{8'h08, 0, 0, 4, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};  // ADD
    tbl[1] = '{8'hCD, 1, 3, 8, 1, 4, 1'b1, 1'b0, 1'b0, 1'b0};  // LW, slow dmem
    tbl[2] = '{8'hB2, 0, 0, 4, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0};  // SW
    tbl[3] = '{8'h20, 0, 0, 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};  // illegal 001
    tbl[4] = '{8'h81, 2, 0, 4, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};  // ADDI
    tbl[5] = '{8'hF5, 0, 0, 4, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};  // SLL
    tbl[6] = '{8'h5A, 1, 0, 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};  // illegal 010

    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 8'h00;
    exp_pc = 8'h00; exp_ill = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset reqs", {imem_req, dmem_req, dmem_we}, 0);
    chk("reset pulses", {reg_write, mem_to_reg}, 0);
    chk("reset flags", {halted, illegal_op, bus_err}, 0);
    chk("reset pc", pc, 0);
    chk("reset alu_op", alu_op, 0);

    // Ack while no request is outstanding must be ignored.
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 8'h60;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("stray ack pc", pc, 0);
    chk("stray ack req", imem_req, 1);
    chk("stray ack halted", halted, 0);

    for (int i = 0; i < 7; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

    // Random program long enough to wrap the PC; ADDI is forced at 0xFF.
    for (int i = 0; i < 300; i++) begin
      ins = 8'($urandom);
      if (ins[7:5] == 3'd3) ins[7:5] = 3'd0;
      if (exp_pc == 8'hFF) ins = 8'h81;
      v = model(ins, $urandom_range(0, 3), $urandom_range(0, 3));
      run_instr(v, $sformatf("rnd%0d", i));
    end

    // Reset while a load waits in MEM.
    wait_ireq(ok);
    imem_ack = 1'b1; imem_rdata = 8'hCD;
    @(negedge clk);
    imem_ack = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (dmem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rstmem reached MEM", ok, 1);
    chk("rstmem illegal before", illegal_op, exp_ill);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmem dmem_req", dmem_req, 0);
    chk("rstmem imem_req", imem_req, 0);
    chk("rstmem pc", pc, 0);
    chk("rstmem flags", {halted, illegal_op, bus_err, reg_write}, 0);
    rst = 1'b0; exp_pc = 8'h00; exp_ill = 1'b0;

    // Fetch ack withheld: req held ACK_TMO cycles, then bus error.
    wait_ireq(ok);
    chk("tmo first req", ok, 1);
    bad = 1'b0;
    for (int n = 1; n < ACK_TMO; n++) begin
      @(negedge clk);
      if (imem_req !== 1'b1) bad = 1'b1;
    end
    chk("tmo req held", bad, 0);
    @(negedge clk);
    chk("tmo imem_req", imem_req, 0);
    chk("tmo bus_err", bus_err, 1);
    chk("tmo halted", halted, 1);
    imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = 8'h08;
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1) bad = 1'b1;
    end
    chk("tmo absorbing", bad, 0);
    chk("tmo pc", pc, 0);

    // HALT opcode stops the core with no further requests.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; exp_pc = 8'h00; exp_ill = 1'b0;
    run_instr(model(8'h60, 1, 0), "halt");
    bad = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1) bad = 1'b1;
    end
    chk("halt absorbing", bad, 0);
    chk("halt pc", pc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
